// File: rtl/mem_arb_pkg.sv
// Shared types for the byte-wide SRAM arbiter: FSM encoding, access size
// codes and requester identifiers.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM signal bundle for mem_arbiter; the arbiter takes the
// slave view, requesters and the SRAM model take the master view.
interface mem_arbiter_if;

   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o;

   logic        ls_req_i;
   logic        ls_we_i;
   logic [1:0]  ls_size_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic [31:0] ls_rdata_o;
   logic        ls_ack_o;

   logic        ram_ce_no;
   logic        ram_we_no;
   logic        ram_oe_no;
   logic [31:0] ram_addr_o;
   logic [7:0]  ram_wdata_o;
   logic        ram_wdata_oe_o;
   logic [7:0]  ram_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
      input  ram_rdata_i,
      output if_rdata_o, if_ack_o, ls_rdata_o, ls_ack_o,
      output ram_ce_no, ram_we_no, ram_oe_no, ram_addr_o, ram_wdata_o, ram_wdata_oe_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
      output ram_rdata_i,
      input  if_rdata_o, if_ack_o, ls_rdata_o, ls_ack_o,
      input  ram_ce_no, ram_we_no, ram_oe_no, ram_addr_o, ram_wdata_o, ram_wdata_oe_o
   );

endinterface

// File: rtl/mem_arb_byte_seq.sv
// Strobe timing for one byte access: ACCESS stretched by RAM_WAIT cycles
// via a down-counter, then the RECOVER cycle with only chip enable low.
module mem_arb_byte_seq
   import mem_arb_pkg::*;
#(
   parameter int RAM_WAIT = 0
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  state_t state,
   input  logic   we,
   output logic   ram_ce_no,
   output logic   ram_we_no,
   output logic   ram_oe_no,
   output logic   access_last
);

   logic [1:0] wait_q;

   // Reloaded whenever not in ACCESS, so every byte starts a fresh count.
   always_ff @(posedge clk_i) begin
      if (rst_i || state != ST_ACCESS) begin
         wait_q <= 2'(RAM_WAIT);
      end else if (wait_q != 2'd0) begin
         wait_q <= wait_q - 2'd1;
      end
   end

   assign access_last = (state == ST_ACCESS) && (wait_q == 2'd0);

   assign ram_ce_no = !((state == ST_ACCESS) || (state == ST_RECOVER));
   assign ram_oe_no = !((state == ST_ACCESS) && !we);
   assign ram_we_no = !((state == ST_ACCESS) && we);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a byte-wide SRAM.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed ls priority.
//
// state   | meaning
// IDLE    | waiting for a request while boot_i is low
// ACCESS  | byte k strobed (1+RAM_WAIT cycles), read byte captured on last cycle
// RECOVER | ce held, we/oe released; advance k or finish
// DONE    | single-cycle ack to the granted requester
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RAM_WAIT = 0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         boot_i,
   mem_arbiter_if.slave bus
);

   state_t      state_q, state_d;
   logic        gnt_id_q;
   logic        pick_id;
   logic        grant;
   logic        access_last;
   logic        last_byte;
   logic        active;
   logic        we_q;
   logic [2:0]  n_q;
   logic [1:0]  k_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] result_q;
   logic [31:0] if_rdata_q;
   logic [31:0] ls_rdata_q;

   assign grant     = (state_q == ST_IDLE) && !boot_i && (bus.if_req_i || bus.ls_req_i);
   assign last_byte = (({1'b0, k_q} + 3'd1) == n_q);
   assign active    = (state_q == ST_ACCESS) || (state_q == ST_RECOVER);

`ifdef MEM_ARB_RR_EN
   logic prio_ls_q;

   // Priority passes to whichever requester was not granted last.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_ls_q <= 1'b1;
      end else if (grant) begin
         prio_ls_q <= (pick_id != REQ_LS);
      end
   end

   assign pick_id = (bus.ls_req_i && (!bus.if_req_i || prio_ls_q)) ? REQ_LS : REQ_IF;
`else
   assign pick_id = bus.ls_req_i ? REQ_LS : REQ_IF;
`endif

   mem_arb_byte_seq #(
      .RAM_WAIT(RAM_WAIT)
   ) u_byte_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .state      (state_q),
      .we         (we_q),
      .ram_ce_no  (bus.ram_ce_no),
      .ram_we_no  (bus.ram_we_no),
      .ram_oe_no  (bus.ram_oe_no),
      .access_last(access_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      bus.if_ack_o       = 1'b0;
      bus.ls_ack_o       = 1'b0;
      bus.ram_addr_o     = '0;
      bus.ram_wdata_o    = '0;
      bus.ram_wdata_oe_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (access_last) state_d = ST_RECOVER;
         end
         ST_RECOVER: begin
            state_d = last_byte ? ST_DONE : ST_ACCESS;
         end
         ST_DONE: begin
            state_d      = ST_IDLE;
            bus.if_ack_o = (gnt_id_q == REQ_IF);
            bus.ls_ack_o = (gnt_id_q == REQ_LS);
         end
         default: state_d = ST_IDLE;
      endcase
      // Address and write data stay put through RECOVER for SRAM hold time.
      if (active) begin
         bus.ram_addr_o = addr_q + {30'd0, k_q};
         if (we_q) begin
            bus.ram_wdata_o    = 8'(wdata_q >> {k_q, 3'b000});
            bus.ram_wdata_oe_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_id_q   <= REQ_LS;
         we_q       <= 1'b0;
         n_q        <= 3'd0;
         k_q        <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         if (grant) begin
            gnt_id_q <= pick_id;
            addr_q   <= (pick_id == REQ_LS) ? bus.ls_addr_i : bus.if_addr_i;
            we_q     <= (pick_id == REQ_LS) && bus.ls_we_i;
            n_q      <= (pick_id == REQ_LS) ? byte_count(bus.ls_size_i) : 3'd4;
            wdata_q  <= bus.ls_wdata_i;
            k_q      <= 2'd0;
            result_q <= '0;
         end
         if (access_last && !we_q) begin
            result_q[{k_q, 3'b000} +: 8] <= bus.ram_rdata_i;
         end
         if (state_q == ST_RECOVER) begin
            k_q <= k_q + 2'd1;
            // Writes leave the requester's last read value untouched.
            if (last_byte && !we_q) begin
               if (gnt_id_q == REQ_LS) ls_rdata_q <= result_q;
               else                    if_rdata_q <= result_q;
            end
         end
      end
   end

   assign bus.if_rdata_o = if_rdata_q;
   assign bus.ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (byte lists, little-endian assembly, arbitration rule).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int W0 = 0;

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [7:0]  d;
   } acc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic boot = 1'b0;
   logic boot2 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int strobe_err = 0;

   logic [7:0] sram    [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];
   acc_t       log_q[$];

   logic        t_ls_we;
   logic [1:0]  t_ls_size;
   logic [31:0] t_ls_addr;
   logic [31:0] t_ls_wdata;
   logic [31:0] t_if_addr;
   logic [31:0] m_if_rd = '0;
   logic [31:0] m_ls_rd = '0;
   logic        prio_m  = 1'b1;

   mem_arbiter_if bus ();
   mem_arbiter_if bus2 ();

   mem_arbiter #(.RAM_WAIT(W0)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .boot_i(boot),
      .bus   (bus)
   );

   mem_arbiter #(.RAM_WAIT(2)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .boot_i(boot2),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] sram_rd(input logic [31:0] a);
      return sram.exists(a) ? sram[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // SRAM device model and strobe observer
   always @(posedge clk) begin
      if (bus.ram_ce_no === 1'b0 && (bus.ram_oe_no === 1'b0 || bus.ram_we_no === 1'b0)) begin
         log_q.push_back('{bus.ram_addr_o, !bus.ram_we_no, bus.ram_wdata_o});
         if (bus.ram_we_no === 1'b0) sram[bus.ram_addr_o] = bus.ram_wdata_o;
      end
      if (bus.ram_ce_no === 1'b1 &&
          (bus.ram_we_no !== 1'b1 || bus.ram_oe_no !== 1'b1 || bus.ram_wdata_oe_o !== 1'b0))
         strobe_err++;
      if (bus.ram_we_no === 1'b0 && bus.ram_oe_no === 1'b0) strobe_err++;
      if (bus.ram_we_no === 1'b0 && bus.ram_wdata_oe_o !== 1'b1) strobe_err++;
   end

   always @(negedge clk) begin
      bus.ram_rdata_i = (bus.ram_oe_no === 1'b0) ? sram_rd(bus.ram_addr_o) : 8'hEE;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
      t_ls_we = we; t_ls_size = size; t_ls_addr = addr; t_ls_wdata = wdata;
      bus.ls_we_i = we; bus.ls_size_i = size; bus.ls_addr_i = addr; bus.ls_wdata_i = wdata;
      bus.ls_req_i = 1'b1;
   endtask

   task automatic drive_if(input logic [31:0] addr);
      t_if_addr = addr;
      bus.if_addr_i = addr;
      bus.if_req_i = 1'b1;
   endtask

   // Call in the cycle the expected requester is granted (DUT idle, #1 after edge).
   task automatic serve(input logic exp_ls);
      int n, c, lat;
      logic we, got;
      logic [31:0] a, exp_rd;
      n      = exp_ls ? nbytes(t_ls_size) : 4;
      we     = exp_ls && t_ls_we;
      a      = exp_ls ? t_ls_addr : t_if_addr;
      lat    = 1 + n * (2 + W0);
      exp_rd = '0;
      for (int i = 0; i < n; i++) begin
         if (we) ref_mem[a + 32'(i)] = t_ls_wdata[8*i +: 8];
         else    exp_rd = exp_rd | (32'(ref_rd(a + 32'(i))) << (8 * i));
      end
      log_q.delete();
      c = 0;
      got = 1'b0;
      while (!got && c < 60) begin
         @(posedge clk); #1;
         c++;
         got = bus.if_ack_o | bus.ls_ack_o;
      end
      check("ack_seen", 32'(got), 32'd1);
      check("ack_who", {30'd0, bus.ls_ack_o, bus.if_ack_o}, exp_ls ? 32'd2 : 32'd1);
      check("latency", c, lat);
      if (!exp_ls) m_if_rd = exp_rd;
      else if (!we) m_ls_rd = exp_rd;
      check("if_rdata", bus.if_rdata_o, m_if_rd);
      if (!(exp_ls && we)) check("ls_rdata", bus.ls_rdata_o, m_ls_rd);
      check("n_access", log_q.size(), n);
      for (int i = 0; i < n && i < log_q.size(); i++) begin
         check("acc_addr", log_q[i].a, a + 32'(i));
         check("acc_we", 32'(log_q[i].w), 32'(we));
         if (we) check("acc_wdata", 32'(log_q[i].d), 32'(t_ls_wdata[8*i +: 8]));
      end
      prio_m = !exp_ls;
      if (exp_ls) bus.ls_req_i = 1'b0;
      else        bus.if_req_i = 1'b0;
      @(posedge clk); #1;
      check("ack_pulse", {30'd0, bus.ls_ack_o, bus.if_ack_o}, 32'd0);
   endtask

   task automatic serve_pair();
      logic first;
`ifdef MEM_ARB_RR_EN
      first = prio_m;
`else
      first = 1'b1;
`endif
      serve(first);
      serve(!first);
   endtask

   initial begin
      logic [7:0]  pre [4];
      logic [31:0] la;
      int          mode, c, seen, oe_cnt;

      bus.if_req_i = 1'b0; bus.if_addr_i = '0;
      bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_size_i = '0;
      bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
      bus2.if_req_i = 1'b0; bus2.if_addr_i = '0;
      bus2.ls_req_i = 1'b0; bus2.ls_we_i = 1'b0; bus2.ls_size_i = '0;
      bus2.ls_addr_i = '0; bus2.ls_wdata_i = '0;
      bus2.ram_rdata_i = 8'h5C;

      pre = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         sram[32'h10 + 32'(i)]    = pre[i];
         ref_mem[32'h10 + 32'(i)] = pre[i];
      end

      repeat (3) @(posedge clk);
      #1;
      check("rst_ce", 32'(bus.ram_ce_no), 32'd1);
      check("rst_we", 32'(bus.ram_we_no), 32'd1);
      check("rst_oe", 32'(bus.ram_oe_no), 32'd1);
      check("rst_wdata_oe", 32'(bus.ram_wdata_oe_o), 32'd0);
      check("rst_addr", bus.ram_addr_o, 32'd0);
      check("rst_wdata", 32'(bus.ram_wdata_o), 32'd0);
      check("rst_acks", {30'd0, bus.ls_ack_o, bus.if_ack_o}, 32'd0);
      check("rst_if_rdata", bus.if_rdata_o, 32'd0);
      check("rst_ls_rdata", bus.ls_rdata_o, 32'd0);
      rst = 1'b0;

      // word fetch with known contents
      drive_if(32'h10);
      serve(1'b0);
      check("fetch_word", bus.if_rdata_o, 32'h4433_2211);

      // misaligned word store
      drive_ls(1'b1, 2'b10, 32'h21, 32'hDEAD_BEEF);
      serve(1'b1);

      // half load across the top of the address space
      drive_ls(1'b0, 2'b01, 32'hFFFF_FFFF, '0);
      serve(1'b1);
      check("half_upper_zero", {16'd0, bus.ls_rdata_o[31:16]}, 32'd0);

      // simultaneous requests, twice
      for (int r = 0; r < 2; r++) begin
         drive_if(32'h10);
         drive_ls(1'b0, 2'b10, 32'h21, '0);
         serve_pair();
      end

      // boot_i blocks new grants
      boot = 1'b1;
      drive_if(32'h80);
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.if_ack_o !== 1'b0 || bus.ram_ce_no !== 1'b1) seen++;
      end
      check("boot_blocks", seen, 0);
      boot = 1'b0;
      serve(1'b0);

      // boot_i rising mid-transfer does not abort it
      drive_ls(1'b0, 2'b10, 32'h1004, '0);
      fork
         begin
            repeat (3) @(posedge clk);
            #2 boot = 1'b1;
         end
      join_none
      serve(1'b1);
      boot = 1'b0;

      // random traffic
      for (int it = 0; it < 40; it++) begin
         mode = $urandom_range(0, 2);
         la = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                          : 32'h1000 + 32'($urandom_range(0, 31));
         if (mode != 1) drive_if(32'h1000 + 32'($urandom_range(0, 31)));
         if (mode != 0) drive_ls(1'($urandom), 2'($urandom), la, $urandom);
         if (mode == 2) serve_pair();
         else           serve(mode == 1);
      end

      // reset during second byte of a word store
      drive_ls(1'b1, 2'b10, 32'h300, 32'hCAFE_F00D);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("pre_rst_we", 32'(bus.ram_we_no), 32'd0);
      check("pre_rst_addr", bus.ram_addr_o, 32'h301);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ce", 32'(bus.ram_ce_no), 32'd1);
      check("mid_rst_we", 32'(bus.ram_we_no), 32'd1);
      check("mid_rst_oe", 32'(bus.ram_oe_no), 32'd1);
      check("mid_rst_wdata_oe", 32'(bus.ram_wdata_oe_o), 32'd0);
      check("mid_rst_addr", bus.ram_addr_o, 32'd0);
      check("mid_rst_wdata", 32'(bus.ram_wdata_o), 32'd0);
      check("mid_rst_ack", 32'(bus.ls_ack_o), 32'd0);
      check("mid_rst_ls_rdata", bus.ls_rdata_o, 32'd0);
      check("mid_rst_if_rdata", bus.if_rdata_o, 32'd0);
      bus.ls_req_i = 1'b0;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.ls_ack_o !== 1'b0 || bus.ram_ce_no !== 1'b1) seen++;
      end
      check("rst_abort_idle", seen, 0);
      ref_mem[32'h300] = 8'h0D;
      ref_mem[32'h301] = 8'hF0;
      m_if_rd = '0;
      m_ls_rd = '0;
      prio_m  = 1'b1;
      drive_ls(1'b0, 2'b10, 32'h300, '0);
      serve(1'b1);

      // RAM_WAIT=2 byte read on the second instance
      bus2.ls_addr_i = 32'h40;
      bus2.ls_size_i = 2'b00;
      bus2.ls_we_i   = 1'b0;
      bus2.ls_req_i  = 1'b1;
      c = 0;
      oe_cnt = 0;
      seen = 0;
      while (seen == 0 && c < 40) begin
         @(posedge clk); #1;
         c++;
         if (bus2.ram_oe_no === 1'b0) oe_cnt++;
         if (bus2.ls_ack_o === 1'b1) seen = 1;
      end
      check("w2_ack_seen", seen, 1);
      check("w2_latency", c, 5);
      check("w2_oe_cycles", oe_cnt, 3);
      check("w2_rdata", bus2.ls_rdata_o, 32'h0000_005C);
      bus2.ls_req_i = 1'b0;
      @(posedge clk); #1;

      check("strobe_rules", strobe_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
